lif_timestep_scheduler: RTL and testbench



---
 rtl/lif_timestep_scheduler.sv | 164 ++++++++++++++++
 tb/tb_lif_timestep_scheduler.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_timestep_scheduler.sv
// LIF timestep scheduler: drains the spike FIFO, issues one accumulate pass per spike, then one update pass.
// Define LIF_SCHED_STALL_CNT_EN to add the stall_cnt_o back-pressure counter.
module lif_timestep_scheduler #(
   parameter int N_PRE  = 256,
   parameter int N_POST = 256,
   parameter int LANES  = 4,
   parameter int PRE_W  = 8,
   parameter int POST_W = 8,
   parameter int STEP_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   input  logic              spk_valid_i,
   input  logic [PRE_W-1:0]  spk_idx_i,
   input  logic              spk_last_i,
   output logic              spk_ready_o,
   output logic              acc_valid_o,
   output logic [PRE_W-1:0]  acc_pre_o,
   output logic [POST_W-1:0] acc_post_o,
   input  logic              acc_ready_i,
   output logic              upd_valid_o,
   output logic [POST_W-1:0] upd_post_o,
   input  logic              upd_ready_i,
   output logic [STEP_W-1:0] step_cnt_o,
   output logic [PRE_W:0]    spk_cnt_o
`ifdef LIF_SCHED_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cnt_o
`endif
);

   localparam int N_GRP = N_POST / LANES;
   localparam int GRP_W = (N_GRP > 1) ? $clog2(N_GRP) : 1;
   localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(N_GRP - 1);
   localparam logic [PRE_W:0]   SPK_MAX  = (PRE_W+1)'(N_PRE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ACCUM,
      S_UPDATE,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [PRE_W-1:0]  pre_q, pre_d;
   logic [GRP_W-1:0]  g_q, g_d;
   logic [PRE_W:0]    spk_cnt_q, spk_cnt_d;
   logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
   logic [POST_W-1:0] grp_base;

   // First neuron of the current lane group; shared by both command streams.
   assign grp_base = POST_W'(32'(g_q) * LANES);

   always_comb begin
      state_d    = state_q;
      pre_d      = pre_q;
      g_d        = g_q;
      spk_cnt_d  = spk_cnt_q;
      step_cnt_d = step_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d   = S_FETCH;
               spk_cnt_d = '0;
            end
         end
         S_FETCH: begin
            if (spk_valid_i) begin
               g_d = '0;
               if (spk_last_i) begin
                  state_d = S_UPDATE;
               end else begin
                  pre_d   = spk_idx_i;
                  state_d = S_ACCUM;
                  if (spk_cnt_q != SPK_MAX) begin
                     spk_cnt_d = spk_cnt_q + 1'b1;
                  end
               end
            end
         end
         S_ACCUM: begin
            if (acc_ready_i) begin
               g_d = g_q + 1'b1;
               if (g_q == LAST_GRP) begin
                  state_d = S_FETCH;
               end
            end
         end
         S_UPDATE: begin
            if (upd_ready_i) begin
               g_d = g_q + 1'b1;
               if (g_q == LAST_GRP) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            step_cnt_d = step_cnt_q + 1'b1;
            state_d    = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decode from registered state and payload only, so ready never feeds valid.
   always_comb begin
      busy_o      = (state_q != S_IDLE);
      done_o      = (state_q == S_DONE);
      spk_ready_o = (state_q == S_FETCH);
      acc_valid_o = (state_q == S_ACCUM);
      upd_valid_o = (state_q == S_UPDATE);
      acc_pre_o   = pre_q;
      acc_post_o  = grp_base;
      upd_post_o  = grp_base;
      step_cnt_o  = step_cnt_q;
      spk_cnt_o   = spk_cnt_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         pre_q      <= '0;
         g_q        <= '0;
         spk_cnt_q  <= '0;
         step_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         pre_q      <= pre_d;
         g_q        <= g_d;
         spk_cnt_q  <= spk_cnt_d;
         step_cnt_q <= step_cnt_d;
      end
   end

`ifdef LIF_SCHED_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (state_q == S_IDLE && start_i) begin
         stall_cnt_d = '0;
      end else if ((acc_valid_o && !acc_ready_i) || (upd_valid_o && !upd_ready_i)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_lif_timestep_scheduler.sv
// Directed bench for lif_timestep_scheduler: scenario tasks with hand-computed expectations.
module tb_lif_timestep_scheduler;

   localparam int LOG = 16448;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_i = 1'b0;
   logic        busy_o, done_o;
   logic        spk_valid_i = 1'b0;
   logic [7:0]  spk_idx_i = 8'h00;
   logic        spk_last_i = 1'b0;
   logic        spk_ready_o;
   logic        acc_valid_o;
   logic [7:0]  acc_pre_o, acc_post_o;
   logic        acc_ready_i = 1'b1;
   logic        upd_valid_o;
   logic [7:0]  upd_post_o;
   logic        upd_ready_i = 1'b1;
   logic [15:0] step_cnt_o;
   logic [8:0]  spk_cnt_o;
`ifdef LIF_SCHED_STALL_CNT_EN
   logic [31:0] stall_cnt_o;
`endif

   int vec_cnt = 0;
   int err_cnt = 0;

   int         n_words;
   logic [7:0] w_idx  [0:299];
   logic       w_last [0:299];
   logic [7:0] acc_pre_log  [0:LOG-1];
   logic [7:0] acc_post_log [0:LOG-1];
   logic [7:0] upd_post_log [0:127];
   int acc_n, upd_n, done_cnt, done_edge, stable_err, both_err, n_edges;
   bit timeout;

   lif_timestep_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .spk_valid_i (spk_valid_i),
      .spk_idx_i   (spk_idx_i),
      .spk_last_i  (spk_last_i),
      .spk_ready_o (spk_ready_o),
      .acc_valid_o (acc_valid_o),
      .acc_pre_o   (acc_pre_o),
      .acc_post_o  (acc_post_o),
      .acc_ready_i (acc_ready_i),
      .upd_valid_o (upd_valid_o),
      .upd_post_o  (upd_post_o),
      .upd_ready_i (upd_ready_i),
      .step_cnt_o  (step_cnt_o),
`ifdef LIF_SCHED_STALL_CNT_EN
      .stall_cnt_o (stall_cnt_o),
`endif
      .spk_cnt_o   (spk_cnt_o)
   );

   always #5 clk = ~clk;

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic set_single_spike(input logic [7:0] idx);
      n_words = 2;
      w_idx[0] = idx;   w_last[0] = 1'b0;
      w_idx[1] = 8'h00; w_last[1] = 1'b1;
   endtask

   // Runs one timestep from start to three idle cycles after done, logging every command handshake.
   task automatic run_timestep(input bit acc_pat, input int upd_hold, input bit restart, input int max_edges);
      int wp, hold_n, idle_n;
      logic p_av, p_ar, p_uv, p_ur;
      logic [7:0] p_pre, p_apost, p_upost;
      bit hs;
      wp = 0; hold_n = 0; idle_n = 0;
      acc_n = 0; upd_n = 0; done_cnt = 0; done_edge = -1;
      stable_err = 0; both_err = 0; timeout = 0;
      p_av = 0; p_ar = 0; p_uv = 0; p_ur = 0;
      p_pre = 0; p_apost = 0; p_upost = 0;
      acc_ready_i = 1'b1;
      upd_ready_i = 1'b1;
      spk_valid_i = (n_words > 0);
      spk_idx_i   = w_idx[0];
      spk_last_i  = w_last[0];
      start_i     = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      n_edges = 1;
      forever begin
         if (acc_valid_o && upd_valid_o) both_err++;
         if (p_av && !p_ar && (acc_valid_o !== 1'b1 || acc_pre_o !== p_pre || acc_post_o !== p_apost))
            stable_err++;
         if (p_uv && !p_ur && (upd_valid_o !== 1'b1 || upd_post_o !== p_upost))
            stable_err++;
         if (done_o) begin
            done_cnt++;
            if (done_edge < 0) done_edge = n_edges;
         end
         if (done_cnt > 0 && !busy_o) idle_n++;
         if (idle_n >= 3) break;
         if (n_edges >= max_edges) begin
            timeout = 1;
            break;
         end
         acc_ready_i = !acc_pat || (n_edges % 3 != 0);
         upd_ready_i = !(upd_valid_o && upd_n == 0 && hold_n < upd_hold);
         if (upd_valid_o && !upd_ready_i) hold_n++;
         start_i = restart && upd_valid_o && (upd_n == 10);
         spk_valid_i = (wp < n_words);
         if (wp < n_words) begin
            spk_idx_i  = w_idx[wp];
            spk_last_i = w_last[wp];
         end
         if (acc_valid_o && acc_ready_i) begin
            if (acc_n < LOG) begin
               acc_pre_log[acc_n]  = acc_pre_o;
               acc_post_log[acc_n] = acc_post_o;
            end
            acc_n++;
         end
         if (upd_valid_o && upd_ready_i) begin
            if (upd_n < 128) upd_post_log[upd_n] = upd_post_o;
            upd_n++;
         end
         hs = spk_valid_i && spk_ready_o;
         p_av = acc_valid_o; p_ar = acc_ready_i; p_pre = acc_pre_o; p_apost = acc_post_o;
         p_uv = upd_valid_o; p_ur = upd_ready_i; p_upost = upd_post_o;
         @(posedge clk);
         #1;
         n_edges++;
         if (hs) wp++;
      end
      start_i = 1'b0;
      spk_valid_i = 1'b0;
      acc_ready_i = 1'b1;
      upd_ready_i = 1'b1;
   endtask

   task automatic test_reset();
      start_i = 1'b1; spk_valid_i = 1'b1; spk_idx_i = 8'h55; spk_last_i = 1'b0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vec_cnt++;
      if ({busy_o, done_o, spk_ready_o, acc_valid_o, upd_valid_o} !== 5'b0) begin
         err_cnt++;
         $display("FAIL reset_flags: got %b expected 00000", {busy_o, done_o, spk_ready_o, acc_valid_o, upd_valid_o});
      end
      vec_cnt++;
      if ({acc_pre_o, acc_post_o, upd_post_o} !== 24'h0) begin
         err_cnt++;
         $display("FAIL reset_payload: got pre=%h apost=%h upost=%h expected 0", acc_pre_o, acc_post_o, upd_post_o);
      end
      vec_cnt++;
      if (step_cnt_o !== 16'd0 || spk_cnt_o !== 9'd0) begin
         err_cnt++;
         $display("FAIL reset_counters: got step=%0d spk=%0d expected 0/0", step_cnt_o, spk_cnt_o);
      end
      @(negedge clk);
      rst = 1'b1; start_i = 1'b0; spk_valid_i = 1'b0;
      @(posedge clk);
      #1;
      vec_cnt++;
      if (busy_o !== 1'b0) begin
         err_cnt++;
         $display("FAIL idle_after_reset: busy=%b expected 0", busy_o);
      end
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      vec_cnt++;
      if (busy_o !== 1'b1 || spk_ready_o !== 1'b1) begin
         err_cnt++;
         $display("FAIL start_busy: busy=%b ready=%b expected 1/1", busy_o, spk_ready_o);
      end
      pulse_reset();
      $display("test_reset done");
   endtask

   task automatic test_single_spike();
      set_single_spike(8'h2A);
      run_timestep(1'b0, 0, 1'b0, 500);
      vec_cnt++;
      if (timeout || acc_n !== 64 || upd_n !== 64) begin
         err_cnt++;
         $display("FAIL single_counts: timeout=%0d acc=%0d upd=%0d expected 0/64/64", timeout, acc_n, upd_n);
      end
      for (int i = 0; i < 64; i++) begin
         vec_cnt++;
         if (acc_pre_log[i] !== 8'h2A || acc_post_log[i] !== 8'(i * 4)) begin
            err_cnt++;
            $display("FAIL single_acc[%0d]: got pre=%h post=%0d expected 2a/%0d", i, acc_pre_log[i], acc_post_log[i], i * 4);
         end
         vec_cnt++;
         if (upd_post_log[i] !== 8'(i * 4)) begin
            err_cnt++;
            $display("FAIL single_upd[%0d]: got %0d expected %0d", i, upd_post_log[i], i * 4);
         end
      end
      vec_cnt++;
      if (done_cnt !== 1 || done_edge + 1 !== 132) begin
         err_cnt++;
         $display("FAIL single_latency: done_cnt=%0d cycles=%0d expected 1/132", done_cnt, done_edge + 1);
      end
      vec_cnt++;
      if (spk_cnt_o !== 9'd1 || step_cnt_o !== 16'd1) begin
         err_cnt++;
         $display("FAIL single_stats: spk=%0d step=%0d expected 1/1", spk_cnt_o, step_cnt_o);
      end
      $display("test_single_spike done: acc=%0d upd=%0d cycles=%0d", acc_n, upd_n, done_edge + 1);
   endtask

   task automatic test_empty();
      n_words = 1;
      w_idx[0] = 8'h77; w_last[0] = 1'b1;
      run_timestep(1'b0, 0, 1'b0, 300);
      vec_cnt++;
      if (timeout || acc_n !== 0 || upd_n !== 64) begin
         err_cnt++;
         $display("FAIL empty_counts: timeout=%0d acc=%0d upd=%0d expected 0/0/64", timeout, acc_n, upd_n);
      end
      vec_cnt++;
      if (upd_post_log[0] !== 8'd0 || upd_post_log[63] !== 8'd252) begin
         err_cnt++;
         $display("FAIL empty_upd_range: got first=%0d last=%0d expected 0/252", upd_post_log[0], upd_post_log[63]);
      end
      vec_cnt++;
      if (done_cnt !== 1 || done_edge + 1 !== 67) begin
         err_cnt++;
         $display("FAIL empty_latency: done_cnt=%0d cycles=%0d expected 1/67", done_cnt, done_edge + 1);
      end
      vec_cnt++;
      if (spk_cnt_o !== 9'd0 || step_cnt_o !== 16'd2) begin
         err_cnt++;
         $display("FAIL empty_stats: spk=%0d step=%0d expected 0/2", spk_cnt_o, step_cnt_o);
      end
      $display("test_empty done: acc=%0d upd=%0d", acc_n, upd_n);
   endtask

   task automatic test_dup_stall();
      int bad;
      n_words = 4;
      w_idx[0] = 8'd3;   w_last[0] = 1'b0;
      w_idx[1] = 8'd3;   w_last[1] = 1'b0;
      w_idx[2] = 8'd255; w_last[2] = 1'b0;
      w_idx[3] = 8'd0;   w_last[3] = 1'b1;
      run_timestep(1'b1, 0, 1'b0, 2000);
      vec_cnt++;
      if (timeout || acc_n !== 192 || upd_n !== 64) begin
         err_cnt++;
         $display("FAIL dup_counts: timeout=%0d acc=%0d upd=%0d expected 0/192/64", timeout, acc_n, upd_n);
      end
      bad = 0;
      for (int i = 0; i < 192; i++) begin
         if (acc_pre_log[i] !== ((i < 128) ? 8'd3 : 8'd255) || acc_post_log[i] !== 8'((i % 64) * 4)) bad++;
      end
      vec_cnt++;
      if (bad !== 0) begin
         err_cnt++;
         $display("FAIL dup_sequence: got %0d wrong beats expected 0", bad);
      end
      vec_cnt++;
      if (stable_err !== 0 || both_err !== 0) begin
         err_cnt++;
         $display("FAIL dup_stability: unstable=%0d overlap=%0d expected 0/0", stable_err, both_err);
      end
      vec_cnt++;
      if (spk_cnt_o !== 9'd3 || step_cnt_o !== 16'd3 || done_cnt !== 1) begin
         err_cnt++;
         $display("FAIL dup_stats: spk=%0d step=%0d done=%0d expected 3/3/1", spk_cnt_o, step_cnt_o, done_cnt);
      end
      $display("test_dup_stall done: acc=%0d cycles=%0d", acc_n, done_edge + 1);
   endtask

   task automatic test_saturation();
      n_words = 258;
      for (int i = 0; i < 257; i++) begin
         w_idx[i] = 8'(i);
         w_last[i] = 1'b0;
      end
      w_idx[257] = 8'd0; w_last[257] = 1'b1;
      run_timestep(1'b0, 0, 1'b0, 20000);
      vec_cnt++;
      if (timeout || acc_n !== 16448) begin
         err_cnt++;
         $display("FAIL sat_counts: timeout=%0d acc=%0d expected 0/16448", timeout, acc_n);
      end
      vec_cnt++;
      if (acc_pre_log[16447] !== 8'd0 || acc_pre_log[16383] !== 8'd255) begin
         err_cnt++;
         $display("FAIL sat_rows: got last=%0d prev=%0d expected 0/255", acc_pre_log[16447], acc_pre_log[16383]);
      end
      vec_cnt++;
      if (spk_cnt_o !== 9'd256 || step_cnt_o !== 16'd4) begin
         err_cnt++;
         $display("FAIL sat_stats: spk=%0d step=%0d expected 256/4", spk_cnt_o, step_cnt_o);
      end
      $display("test_saturation done: spk_cnt=%0d", spk_cnt_o);
   endtask

   task automatic test_back_to_back();
      pulse_reset();
      vec_cnt++;
      if (step_cnt_o !== 16'd0 || busy_o !== 1'b0) begin
         err_cnt++;
         $display("FAIL b2b_reset: step=%0d busy=%b expected 0/0", step_cnt_o, busy_o);
      end
      set_single_spike(8'h10);
      run_timestep(1'b0, 0, 1'b1, 500);
      vec_cnt++;
      if (timeout || done_cnt !== 1 || busy_o !== 1'b0 || upd_n !== 64) begin
         err_cnt++;
         $display("FAIL b2b_ignore_start: timeout=%0d done=%0d busy=%b upd=%0d expected 0/1/0/64", timeout, done_cnt, busy_o, upd_n);
      end
      vec_cnt++;
      if (step_cnt_o !== 16'd1) begin
         err_cnt++;
         $display("FAIL b2b_step1: got %0d expected 1", step_cnt_o);
      end
      run_timestep(1'b0, 0, 1'b0, 500);
      vec_cnt++;
      if (timeout || done_cnt !== 1 || step_cnt_o !== 16'd2) begin
         err_cnt++;
         $display("FAIL b2b_step2: timeout=%0d done=%0d step=%0d expected 0/1/2", timeout, done_cnt, step_cnt_o);
      end
      $display("test_back_to_back done: step_cnt=%0d", step_cnt_o);
   endtask

   task automatic test_upd_stall();
      set_single_spike(8'h05);
      run_timestep(1'b0, 5, 1'b0, 500);
      vec_cnt++;
      if (timeout || done_edge + 1 !== 137 || stable_err !== 0) begin
         err_cnt++;
         $display("FAIL stall_latency: timeout=%0d cycles=%0d unstable=%0d expected 0/137/0", timeout, done_edge + 1, stable_err);
      end
`ifdef LIF_SCHED_STALL_CNT_EN
      vec_cnt++;
      if (stall_cnt_o !== 32'd5) begin
         err_cnt++;
         $display("FAIL stall_cnt: got %0d expected 5", stall_cnt_o);
      end
`endif
      $display("test_upd_stall done: cycles=%0d", done_edge + 1);
   endtask

   task automatic test_reset_mid();
      bit found;
      found = 0;
      set_single_spike(8'h11);
      spk_valid_i = 1'b1; spk_idx_i = 8'h11; spk_last_i = 1'b0;
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (acc_valid_o && acc_post_o == 8'd40) begin
            found = 1;
            break;
         end
         spk_valid_i = !spk_ready_o ? 1'b0 : 1'b1;
         @(posedge clk);
         #1;
      end
      vec_cnt++;
      if (!found) begin
         err_cnt++;
         $display("FAIL mid_reach_group10: got not reached expected reached");
      end
      spk_valid_i = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      vec_cnt++;
      if ({busy_o, acc_valid_o, upd_valid_o, spk_ready_o, done_o} !== 5'b0 || acc_post_o !== 8'd0 || acc_pre_o !== 8'd0) begin
         err_cnt++;
         $display("FAIL mid_async_reset: flags=%b pre=%h post=%0d expected 0", {busy_o, acc_valid_o, upd_valid_o, spk_ready_o, done_o}, acc_pre_o, acc_post_o);
      end
      vec_cnt++;
      if (spk_cnt_o !== 9'd0 || step_cnt_o !== 16'd0) begin
         err_cnt++;
         $display("FAIL mid_reset_counters: spk=%0d step=%0d expected 0/0", spk_cnt_o, step_cnt_o);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vec_cnt++;
      if (busy_o !== 1'b0 || acc_valid_o !== 1'b0 || spk_ready_o !== 1'b0) begin
         err_cnt++;
         $display("FAIL mid_no_resume: busy=%b acc_valid=%b ready=%b expected 0/0/0", busy_o, acc_valid_o, spk_ready_o);
      end
      spk_valid_i = 1'b0;
      $display("test_reset_mid done");
   endtask

   initial begin
      test_reset();
      test_single_spike();
      test_empty();
      test_dup_stall();
      test_saturation();
      test_back_to_back();
      test_upd_stall();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
